// File: rtl/mant_align_right.sv
// Two-stage alignment shifter: picks the larger-exponent operand and right-shifts the other into the extended width.
// Define ALIGN_STICKY_EN to fold the shifted-out bits into bit 0 of o_m_small as a sticky bit.
module mant_align_right #(
  parameter int WIDTH_IN = 24,
  parameter int WIDTH    = 27,
  parameter int EXP_W    = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  input  logic [EXP_W-1:0]    i_exp_a,
  input  logic [EXP_W-1:0]    i_exp_b,
  input  logic [WIDTH_IN-1:0] i_m_a,
  input  logic [WIDTH_IN-1:0] i_m_b,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic [EXP_W-1:0]    o_exp_out,
  output logic [WIDTH-1:0]    o_m_big,
  output logic [WIDTH-1:0]    o_m_small,
  output logic                o_swapped
);

  localparam int DW  = $clog2(WIDTH + 1);
  localparam int PAD = WIDTH - WIDTH_IN;

  logic                r_v1;
  logic [EXP_W-1:0]    r_exp1;
  logic [WIDTH-1:0]    r_big1;
  logic [WIDTH-1:0]    r_small1;
  logic [DW-1:0]       r_d1;
  logic                r_sw1;

  logic                w_adv1;
  logic                w_adv2;
  logic                w_a_big;
  logic [EXP_W-1:0]    w_exp_big;
  logic [EXP_W-1:0]    w_exp_small;
  logic [WIDTH_IN-1:0] w_big;
  logic [WIDTH_IN-1:0] w_small;
  logic [EXP_W-1:0]    w_diff;
  logic [DW-1:0]       w_d;
  logic [WIDTH-1:0]    w_shifted;
  logic [WIDTH-1:0]    w_m_small;

  // Flow control: each stage advances when it is empty or the stage after it moves.
  always_comb begin
    w_adv2     = !o_out_valid || i_out_ready;
    w_adv1     = !r_v1 || w_adv2;
    o_in_ready = w_adv1;
  end

  // Stage 1 compare/swap; ties go to operand a, distance saturates at WIDTH.
  always_comb begin
    w_a_big = (i_exp_a >= i_exp_b);
    if (w_a_big) begin
      w_exp_big   = i_exp_a;
      w_exp_small = i_exp_b;
      w_big       = i_m_a;
      w_small     = i_m_b;
    end else begin
      w_exp_big   = i_exp_b;
      w_exp_small = i_exp_a;
      w_big       = i_m_b;
      w_small     = i_m_a;
    end
    w_diff = w_exp_big - w_exp_small;
    if (32'(w_diff) >= 32'(WIDTH)) begin
      w_d = DW'(WIDTH);
    end else begin
      w_d = DW'(w_diff);
    end
  end

`ifdef ALIGN_STICKY_EN
  logic [WIDTH-1:0] w_mask;
  logic             w_sticky;

  // Stage 2 shift with sticky: mask covers exactly the bits that fall off the bottom.
  always_comb begin
    w_shifted = r_small1 >> r_d1;
    w_mask    = ~({WIDTH{1'b1}} << r_d1);
    w_sticky  = |(r_small1 & w_mask);
    w_m_small = {w_shifted[WIDTH-1:1], w_shifted[0] | w_sticky};
  end
`else
  // Stage 2 shift, shifted-out bits are simply dropped.
  always_comb begin
    w_shifted = r_small1 >> r_d1;
    w_m_small = w_shifted;
  end
`endif

  // Stage 1 registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_v1     <= 1'b0;
      r_exp1   <= {EXP_W{1'b0}};
      r_big1   <= {WIDTH{1'b0}};
      r_small1 <= {WIDTH{1'b0}};
      r_d1     <= {DW{1'b0}};
      r_sw1    <= 1'b0;
    end else if (w_adv1) begin
      r_v1 <= i_in_valid;
      if (i_in_valid) begin
        r_exp1   <= w_exp_big;
        r_big1   <= {w_big, {PAD{1'b0}}};
        r_small1 <= {w_small, {PAD{1'b0}}};
        r_d1     <= w_d;
        r_sw1    <= !w_a_big;
      end
    end
  end

  // Stage 2 (output) registers, held while the consumer stalls.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_out_valid <= 1'b0;
      o_exp_out   <= {EXP_W{1'b0}};
      o_m_big     <= {WIDTH{1'b0}};
      o_m_small   <= {WIDTH{1'b0}};
      o_swapped   <= 1'b0;
    end else if (w_adv2) begin
      o_out_valid <= r_v1;
      if (r_v1) begin
        o_exp_out <= r_exp1;
        o_m_big   <= r_big1;
        o_m_small <= w_m_small;
        o_swapped <= r_sw1;
      end
    end
  end

endmodule
